// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_controller
// Brief    : NES $4014 sprite DMA sequencer and CPU/DMA system-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004,
  parameter int          XFER_LEN  = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rnw,
  input  logic [7:0]  bus_din,
  output logic [15:0] sys_addr,
  output logic [7:0]  sys_dout,
  output logic        sys_rnw,
  output logic        cpu_halt,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] c_last_idx = 8'(XFER_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_page,  w_page_nxt;
  logic [7:0] r_idx,   w_idx_nxt;
  logic [7:0] r_latch, w_latch_nxt;
  logic       r_cyc_odd;
  logic       w_trigger;

  assign w_trigger = (cpu_rnw == 1'b0) && (cpu_addr == TRIG_ADDR);

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_page    <= 8'h00;
      r_idx     <= 8'h00;
      r_latch   <= 8'h00;
      r_cyc_odd <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_page    <= w_page_nxt;
      r_idx     <= w_idx_nxt;
      r_latch   <= w_latch_nxt;
      r_cyc_odd <= ~r_cyc_odd;
    end
  end

  // Next-state logic and output mux; outputs depend only on registers and
  // CPU-side inputs, never on bus_din.
  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_latch_nxt = r_latch;
    sys_addr    = {r_page, r_idx};
    sys_dout    = r_latch;
    sys_rnw     = 1'b1;

    unique case (r_state)
      IDLE: begin
        sys_addr = cpu_addr;
        sys_dout = cpu_dout;
        sys_rnw  = cpu_rnw;
        if (w_trigger) begin
          w_page_nxt  = cpu_dout;
          w_idx_nxt   = 8'h00;
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        // READ must land on an even cycle; an extra ALIGN fixes parity.
        w_state_nxt = r_cyc_odd ? READ : ALIGN;
      end
      ALIGN: begin
        w_state_nxt = READ;
      end
      READ: begin
        w_latch_nxt = bus_din;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        sys_addr = OAM_ADDR;
        sys_rnw  = 1'b0;
        if (r_idx == c_last_idx) begin
          w_idx_nxt   = 8'h00;
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt   = r_idx + 8'h01;
          w_state_nxt = READ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_halt   = (r_state != IDLE);
  assign dma_active = cpu_halt;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_controller
// Brief    : Directed self-checking bench for oam_dma_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic [7:0]  bus_din;
  logic [15:0] sys_addr;
  logic [7:0]  sys_dout;
  logic        sys_rnw;
  logic        cpu_halt;
  logic        dma_active;

  int errors = 0;
  int checks = 0;
  logic tb_par;

  oam_dma_controller dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rnw    (cpu_rnw),
    .bus_din    (bus_din),
    .sys_addr   (sys_addr),
    .sys_dout   (sys_dout),
    .sys_rnw    (sys_rnw),
    .cpu_halt   (cpu_halt),
    .dma_active (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory image: every location holds its low address byte XOR 8'hA5.
  always_comb bus_din = sys_addr[7:0] ^ 8'hA5;

  // Expected free-running cycle parity.
  always @(posedge clk_ph1 or posedge rst) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = 16'h8000; cpu_dout = 8'h00; cpu_rnw = 1'b1;
    #3;
    checks++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0) begin
      errors++; $display("FAIL reset_halt: got halt=%b active=%b want 0 0", cpu_halt, dma_active);
    end
    checks++;
    if (sys_addr !== 16'h8000 || sys_rnw !== 1'b1) begin
      errors++; $display("FAIL reset_pass: got addr=%h rnw=%b want 8000 1", sys_addr, sys_rnw);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    int bad = 0;
    cpu_addr = 16'h8000; cpu_rnw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (sys_addr !== 16'h8000 || sys_rnw !== 1'b1 || cpu_halt !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL cpu_read_pass: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_no_trigger();
    logic [15:0] addrs [3];
    logic        rnws  [3];
    addrs[0] = 16'h4015; rnws[0] = 1'b0;
    addrs[1] = 16'h2004; rnws[1] = 1'b0;
    addrs[2] = 16'h4014; rnws[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = addrs[k]; cpu_rnw = rnws[k]; cpu_dout = 8'h3C + 8'(k);
      #1;
      checks++;
      if (sys_addr !== addrs[k] || sys_rnw !== rnws[k] || sys_dout !== 8'h3C + 8'(k)) begin
        errors++;
        $display("FAIL no_trig_pass%0d: got %h/%b/%h want %h/%b/%h", k, sys_addr, sys_rnw,
                 sys_dout, addrs[k], rnws[k], 8'h3C + 8'(k));
      end
      tick();
      cpu_addr = 16'h8000; cpu_rnw = 1'b1;
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (cpu_halt !== 1'b0) begin
          errors++; $display("FAIL no_trig_halt%0d: got halt=%b want 0", k, cpu_halt);
        end
        tick();
      end
    end
  endtask

  // Runs one DMA. abort_at>0 asserts rst on that write number.
  task automatic run_dma(input logic [7:0] page, input logic want_par,
                         input int exp_len, input int abort_at, input string nm);
    int          halt_cnt = 0;
    int          wr_cnt   = 0;
    int          bad_data = 0;
    int          bad_rd   = 0;
    int          first_wr = -1;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] exp_rd;
    bit          done = 0;
    for (int g = 0; g < 4 && tb_par !== want_par; g++) tick();
    cpu_addr = 16'h4014; cpu_rnw = 1'b0; cpu_dout = page;
    tick();
    cpu_addr = 16'h8000; cpu_rnw = 1'b1; cpu_dout = 8'h00;
    while (!done) begin
      if (cpu_halt !== 1'b1) begin
        done = 1;
      end else begin
        halt_cnt++;
        if (sys_rnw === 1'b0) begin
          if (first_wr < 0) first_wr = halt_cnt;
          if (sys_addr !== 16'h2004 || sys_dout !== (8'(wr_cnt) ^ 8'hA5) || dma_active !== 1'b1)
            bad_data++;
          exp_rd = {page, 8'(wr_cnt)};
          if (prev_addr !== exp_rd) bad_rd++;
          wr_cnt++;
        end
        prev_addr = sys_addr;
        if (abort_at > 0 && wr_cnt == abort_at) begin
          rst = 1'b1;
          #1;
          checks++;
          if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || sys_addr !== 16'h8000 || sys_rnw !== 1'b1) begin
            errors++;
            $display("FAIL %s_async: got halt=%b act=%b addr=%h rnw=%b want 0 0 8000 1",
                     nm, cpu_halt, dma_active, sys_addr, sys_rnw);
          end
          #2 rst = 1'b0;
          tick();
          for (int j = 0; j < 4; j++) begin
            checks++;
            if (cpu_halt !== 1'b0 || sys_rnw !== 1'b1) begin
              errors++; $display("FAIL %s_post: got halt=%b rnw=%b want 0 1", nm, cpu_halt, sys_rnw);
            end
            tick();
          end
          return;
        end
        if (halt_cnt > 600) begin
          done = 1;
        end else begin
          tick();
        end
      end
    end
    checks++;
    if (halt_cnt != exp_len) begin
      errors++; $display("FAIL %s_len: got %0d halted cycles want %0d", nm, halt_cnt, exp_len);
    end
    checks++;
    if (wr_cnt != 256) begin
      errors++; $display("FAIL %s_writes: got %0d writes want 256", nm, wr_cnt);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL %s_data: got %0d bad writes want 0", nm, bad_data);
    end
    checks++;
    if (bad_rd != 0) begin
      errors++; $display("FAIL %s_reads: got %0d bad read addrs want 0", nm, bad_rd);
    end
    checks++;
    if (first_wr != exp_len - 510) begin
      errors++; $display("FAIL %s_first_wr: got cycle %0d want %0d", nm, first_wr, exp_len - 510);
    end
    checks++;
    if (sys_addr !== 16'h8000 || sys_rnw !== 1'b1 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL %s_resume: got addr=%h rnw=%b act=%b want 8000 1 0", nm, sys_addr, sys_rnw, dma_active);
    end
  endtask

  task automatic test_dma_even();
    run_dma(8'h02, 1'b0, 513, 0, "even");
  endtask

  task automatic test_dma_odd();
    run_dma(8'h02, 1'b1, 514, 0, "odd");
  endtask

  task automatic test_page_ff();
    run_dma(8'hFF, 1'b0, 513, 0, "pageff");
  endtask

  task automatic test_abort_restart();
    run_dma(8'h02, 1'b0, 513, 100, "abort");
    run_dma(8'h02, 1'b0, 513, 0, "restart");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_even();
    test_dma_odd();
    test_page_ff();
    test_abort_restart();
    test_no_trigger();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
